dmem_arbiter: RTL and testbench

Two-master arbiter sharing one single-ported on-chip data memory between the core data port and the JTAG/debug master. Transfers are word-wide and Avalon-MM style, with a fixed-latency read return. Read data is steered back to the issuing master through a tag pipeline. Arbitration is round-robin with optional transfer locking. The block sits between core_top's data memory master signals and the Qsys memory slave.

---
 rtl/dmem_arbiter_if.sv | 56 +++++
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data masters, the arbiter and the memory slave.
// slave modport: arbiter view; master modport: masters + memory view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] m0_address;
    logic              m0_read;
    logic              m0_write;
    logic [31:0]       m0_writedata;
    logic [3:0]        m0_byteenable;
    logic              m0_lock;
    logic              m0_waitrequest;
    logic [31:0]       m0_readdata;
    logic              m0_readdatavalid;

    logic [ADDR_W-1:0] m1_address;
    logic              m1_read;
    logic              m1_write;
    logic [31:0]       m1_writedata;
    logic [3:0]        m1_byteenable;
    logic              m1_lock;
    logic              m1_waitrequest;
    logic [31:0]       m1_readdata;
    logic              m1_readdatavalid;

    logic [ADDR_W-1:0] s_address;
    logic              s_read;
    logic              s_write;
    logic [31:0]       s_writedata;
    logic [3:0]        s_byteenable;
    logic [31:0]       s_readdata;

    modport slave (
        input  m0_address, m0_read, m0_write,
        input  m0_writedata, m0_byteenable, m0_lock,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_address, m1_read, m1_write,
        input  m1_writedata, m1_byteenable, m1_lock,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output s_address, s_read, s_write,
        output s_writedata, s_byteenable,
        input  s_readdata
    );

    modport master (
        output m0_address, m0_read, m0_write,
        output m0_writedata, m0_byteenable, m0_lock,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_address, m1_read, m1_write,
        output m1_writedata, m1_byteenable, m1_lock,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  s_address, s_read, s_write,
        input  s_writedata, s_byteenable,
        output s_readdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter: core (m0) and debug (m1) share one data memory.
// Ports: clk, reset (async active-low), bus (slave modport), grant_count.
// Optional transfer locking enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int READ_LATENCY = 2,
    parameter int ADDR_W       = 32
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus,
    output logic [31:0]    grant_count
);
    logic                    w_req0;
    logic                    w_req1;
    logic                    w_gnt0;
    logic                    w_gnt1;
    logic                    w_lock;
    logic                    w_prio_nxt;
    logic [ADDR_W-1:0]       w_s_address;
    logic                    w_s_read;
    logic                    w_s_write;
    logic [31:0]             w_s_writedata;
    logic [3:0]              w_s_byteenable;

    logic                    r_prio;
    logic [READ_LATENCY-1:0] r_tag_v;
    logic [READ_LATENCY-1:0] r_tag_o;
    logic [31:0]             r_grant_count;

    assign w_req0 = bus.m0_read | bus.m0_write;
    assign w_req1 = bus.m1_read | bus.m1_write;

    // Gating with reset keeps the slave idle and both masters stalled
    // for as long as reset is held.
    assign w_gnt0 = reset & w_req0 & (~w_req1 | ~r_prio);
    assign w_gnt1 = reset & w_req1 & (~w_req0 | r_prio);

`ifdef DMEM_ARB_LOCK_EN
    assign w_lock = w_gnt0 ? bus.m0_lock : bus.m1_lock;
`else
    logic w_unused_lock;
    assign w_unused_lock = bus.m0_lock ^ bus.m1_lock;
    assign w_lock = 1'b0;
`endif

    // Winner gets the other master next, or keeps priority when locked.
    always_comb begin
        w_prio_nxt = r_prio;
        if (w_gnt0) begin
            w_prio_nxt = ~w_lock;
        end else if (w_gnt1) begin
            w_prio_nxt = w_lock;
        end
    end

    // m0 fields pass through when idle; write beats read if both set.
    always_comb begin
        w_s_address    = bus.m0_address;
        w_s_writedata  = bus.m0_writedata;
        w_s_byteenable = bus.m0_byteenable;
        w_s_read       = w_gnt0 & bus.m0_read & ~bus.m0_write;
        w_s_write      = w_gnt0 & bus.m0_write;
        if (w_gnt1) begin
            w_s_address    = bus.m1_address;
            w_s_writedata  = bus.m1_writedata;
            w_s_byteenable = bus.m1_byteenable;
            w_s_read       = bus.m1_read & ~bus.m1_write;
            w_s_write      = bus.m1_write;
        end
    end

    assign bus.s_address    = w_s_address;
    assign bus.s_read       = w_s_read;
    assign bus.s_write      = w_s_write;
    assign bus.s_writedata  = w_s_writedata;
    assign bus.s_byteenable = w_s_byteenable;

    assign bus.m0_waitrequest = ~w_gnt0;
    assign bus.m1_waitrequest = ~w_gnt1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prio <= 1'b0;
        end else begin
            r_prio <= w_prio_nxt;
        end
    end

    // Tag pipe: slot 0 loads at the grant edge, tail is seen at T+LAT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tag_v <= '0;
            r_tag_o <= '0;
        end else begin
            r_tag_v[0] <= w_s_read;
            r_tag_o[0] <= w_gnt1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_o[i] <= r_tag_o[i-1];
            end
        end
    end

    assign bus.m0_readdatavalid = r_tag_v[READ_LATENCY-1] &
                                  ~r_tag_o[READ_LATENCY-1];
    assign bus.m1_readdatavalid = r_tag_v[READ_LATENCY-1] &
                                  r_tag_o[READ_LATENCY-1];
    assign bus.m0_readdata      = bus.s_readdata;
    assign bus.m1_readdata      = bus.s_readdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant_count <= '0;
        end else if (w_gnt1 && (r_grant_count != 32'hFFFF_FFFF)) begin
            r_grant_count <= r_grant_count + 32'd1;
        end
    end

    assign grant_count = r_grant_count;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 2-cycle-latency memory model.
// Lock expectations follow DMEM_ARB_LOCK_EN.
module tb_dmem_arbiter;
    logic        clk;
    logic        rst_n;
    logic [31:0] gc;
    int          n_chk;
    int          n_err;

    dmem_arbiter_if #(.ADDR_W(32)) bus ();

    dmem_arbiter #(
        .READ_LATENCY(2),
        .ADDR_W(32)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(bus.slave),
        .grant_count(gc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: word i = A5A5_iiii, word 4 (0x10) starts at zero.
    logic [31:0] mem [0:63];
    logic        mem_init = 1'b0;
    logic [31:0] r_rd1;
    logic [31:0] r_rd2;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= (i == 4) ? 32'h0 : {16'hA5A5, 16'(i)};
            end
            mem_init <= 1'b1;
        end else if (bus.s_write) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.s_byteenable[b]) begin
                    mem[bus.s_address[7:2]][8*b +: 8] <=
                        bus.s_writedata[8*b +: 8];
                end
            end
        end
        r_rd1 <= mem[bus.s_address[7:2]];
        r_rd2 <= r_rd1;
    end

    assign bus.s_readdata = r_rd2;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.m0_read       = 1'b0;
        bus.m0_write      = 1'b0;
        bus.m0_address    = '0;
        bus.m0_writedata  = '0;
        bus.m0_byteenable = 4'hF;
        bus.m0_lock       = 1'b0;
        bus.m1_read       = 1'b0;
        bus.m1_write      = 1'b0;
        bus.m1_address    = '0;
        bus.m1_writedata  = '0;
        bus.m1_byteenable = 4'hF;
        bus.m1_lock       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    logic [6:0] exp_tbl;
    int         rem;
    logic       e1;

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        bus.m0_read = 1'b1;
        bus.m1_read = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_wait0", bus.m0_waitrequest, 1);
        chk("rst_wait1", bus.m1_waitrequest, 1);
        chk("rst_sread", bus.s_read, 0);
        chk("rst_gc", gc, 0);
        chk("rst_rdv0", bus.m0_readdatavalid, 0);
        chk("rst_rdv1", bus.m1_readdatavalid, 0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;

        // m0 alone: three pipelined reads
        @(negedge clk);
        bus.m0_read = 1'b1;
        bus.m0_address = 32'h0;
        #1;
        chk("solo_wait_a", bus.m0_waitrequest, 0);
        chk("solo_sread", bus.s_read, 1);
        chk("solo_saddr", bus.s_address, 32'h0);
        @(negedge clk);
        bus.m0_address = 32'h4;
        #1;
        chk("solo_wait_b", bus.m0_waitrequest, 0);
        @(negedge clk);
        bus.m0_address = 32'h8;
        #1;
        chk("solo_wait_c", bus.m0_waitrequest, 0);
        chk("solo_rdv_a", bus.m0_readdatavalid, 1);
        chk("solo_dat_a", bus.m0_readdata, 32'hA5A5_0000);
        chk("solo_rdv1_a", bus.m1_readdatavalid, 0);
        @(negedge clk);
        idle();
        #1;
        chk("solo_rdv_b", bus.m0_readdatavalid, 1);
        chk("solo_dat_b", bus.m0_readdata, 32'hA5A5_0001);
        @(negedge clk);
        #1;
        chk("solo_rdv_c", bus.m0_readdatavalid, 1);
        chk("solo_dat_c", bus.m0_readdata, 32'hA5A5_0002);
        chk("solo_rdv1_c", bus.m1_readdatavalid, 0);
        @(negedge clk);
        #1;
        chk("solo_rdv_end", bus.m0_readdatavalid, 0);

        // both masters read every cycle from reset
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.m0_read = 1'b1;
        bus.m0_address = 32'h20;
        bus.m1_read = 1'b1;
        bus.m1_address = 32'h30;
        #1;
        chk("rr0_wait0", bus.m0_waitrequest, 0);
        chk("rr0_wait1", bus.m1_waitrequest, 1);
        chk("rr0_saddr", bus.s_address, 32'h20);
        @(negedge clk);
        bus.m0_address = 32'h24;
        #1;
        chk("rr1_wait0", bus.m0_waitrequest, 1);
        chk("rr1_wait1", bus.m1_waitrequest, 0);
        chk("rr1_saddr", bus.s_address, 32'h30);
        @(negedge clk);
        bus.m1_address = 32'h34;
        #1;
        chk("rr2_wait0", bus.m0_waitrequest, 0);
        chk("rr2_wait1", bus.m1_waitrequest, 1);
        chk("rr2_saddr", bus.s_address, 32'h24);
        chk("rr2_rdv0", bus.m0_readdatavalid, 1);
        chk("rr2_rdv1", bus.m1_readdatavalid, 0);
        chk("rr2_dat", bus.m0_readdata, 32'hA5A5_0008);
        @(negedge clk);
        bus.m0_read = 1'b0;
        #1;
        chk("rr3_wait1", bus.m1_waitrequest, 0);
        chk("rr3_saddr", bus.s_address, 32'h34);
        chk("rr3_rdv1", bus.m1_readdatavalid, 1);
        chk("rr3_rdv0", bus.m0_readdatavalid, 0);
        chk("rr3_dat", bus.m1_readdata, 32'hA5A5_000C);
        @(negedge clk);
        idle();
        #1;
        chk("rr4_rdv0", bus.m0_readdatavalid, 1);
        chk("rr4_dat", bus.m0_readdata, 32'hA5A5_0009);
        chk("rr4_gc", gc, 2);
        @(negedge clk);
        #1;
        chk("rr5_rdv1", bus.m1_readdatavalid, 1);
        chk("rr5_dat", bus.m1_readdata, 32'hA5A5_000D);

        // m0 byte-lane write while m1 waits, then m1 reads it back
        @(negedge clk);
        bus.m0_write = 1'b1;
        bus.m0_address = 32'h10;
        bus.m0_writedata = 32'hDEAD_BEEF;
        bus.m0_byteenable = 4'b0011;
        bus.m1_read = 1'b1;
        bus.m1_address = 32'h10;
        #1;
        chk("wr_wait0", bus.m0_waitrequest, 0);
        chk("wr_wait1", bus.m1_waitrequest, 1);
        chk("wr_swrite", bus.s_write, 1);
        chk("wr_sread", bus.s_read, 0);
        chk("wr_sbe", bus.s_byteenable, 4'b0011);
        chk("wr_swd", bus.s_writedata, 32'hDEAD_BEEF);
        @(negedge clk);
        bus.m0_write = 1'b0;
        #1;
        chk("wr_rd_wait1", bus.m1_waitrequest, 0);
        chk("wr_rd_sread", bus.s_read, 1);
        chk("wr_rd_swrite", bus.s_write, 0);
        @(negedge clk);
        idle();
        @(negedge clk);
        #1;
        chk("wr_rdv1", bus.m1_readdatavalid, 1);
        chk("wr_rdv0", bus.m0_readdatavalid, 0);
        chk("wr_dat", bus.m1_readdata, 32'h0000_BEEF);

        // reset with two reads in flight
        @(negedge clk);
        bus.m0_read = 1'b1;
        bus.m0_address = 32'h0;
        @(negedge clk);
        bus.m0_address = 32'h4;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wait0", bus.m0_waitrequest, 1);
        chk("mid_rst_sread", bus.s_read, 0);
        @(negedge clk);
        idle();
        #1;
        chk("mid_rst_rdv0_a", bus.m0_readdatavalid, 0);
        chk("mid_rst_rdv1_a", bus.m1_readdatavalid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_rdv0_b", bus.m0_readdatavalid, 0);
        @(negedge clk);
        bus.m0_read = 1'b1;
        bus.m0_address = 32'h8;
        bus.m1_read = 1'b1;
        bus.m1_address = 32'hC;
        #1;
        chk("post_rst_wait0", bus.m0_waitrequest, 0);
        chk("post_rst_wait1", bus.m1_waitrequest, 1);
        @(negedge clk);
        bus.m0_read = 1'b0;
        #1;
        chk("post_rst_m1", bus.m1_waitrequest, 0);
        @(negedge clk);
        idle();
        #1;
        chk("post_rst_dat0", bus.m0_readdata, 32'hA5A5_0002);
        chk("post_rst_rdv0", bus.m0_readdatavalid, 1);
        @(negedge clk);
        #1;
        chk("post_rst_dat1", bus.m1_readdata, 32'hA5A5_0003);
        chk("post_rst_rdv1", bus.m1_readdatavalid, 1);

        // lock: m1 issues 3 reads (lock 1,1,0), m0 requests continuously
`ifdef DMEM_ARB_LOCK_EN
        exp_tbl = 7'b000_1110;
`else
        exp_tbl = 7'b010_1010;
`endif
        rem = 3;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            bus.m0_read = 1'b1;
            bus.m0_address = 32'h40;
            bus.m1_read = (rem > 0);
            bus.m1_lock = (rem > 1);
            bus.m1_address = 32'h50;
            #1;
            e1 = exp_tbl[c];
            chk($sformatf("lock_c%0d_wait1", c), bus.m1_waitrequest, !e1);
            chk($sformatf("lock_c%0d_wait0", c), bus.m0_waitrequest, e1);
            if (e1) rem--;
        end
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        #1;
        chk("lock_gc", gc, 4);

        // saturation of grant_count
        @(negedge clk);
        force dut.r_grant_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_grant_count;
        #1;
        chk("sat_pre", gc, 32'hFFFF_FFFE);
        @(negedge clk);
        bus.m1_read = 1'b1;
        bus.m1_address = 32'h0;
        #1;
        chk("sat_wait1", bus.m1_waitrequest, 0);
        @(negedge clk);
        #1;
        chk("sat_one", gc, 32'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk);
        idle();
        #1;
        chk("sat_hold", gc, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
